route_sw_scheduler: RTL and testbench

- Generates the capacitor-enable vector `sw` for the route distributor's switch matrix.
- Sequences `sw` frame by frame in one of three modes:
  - static selection;
  - rotating selection (data-weighted averaging, for capacitor mismatch shaping);
  - a one-hot calibration walk.
- Configuration arrives over a valid/ready handshake and is applied only on frame boundaries, so `sw` never changes mid-frame.

---
 rtl/route_sw_scheduler.sv | 143 ++++++++++++++
 tb/tb_route_sw_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/route_sw_scheduler.sv
// Capacitor-enable scheduler for the route distributor switch matrix.
// Produces a frame-synchronous enable vector in static, rotating (DWA) or
// one-hot calibration mode. New configurations are staged in a pending slot
// and only take effect on a frame tick, so sw never changes mid-frame.
module route_sw_scheduler #(
  parameter int CAP_NUM = 8,
  parameter int CNT_W   = 4,
  parameter int PTR_W   = 3,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_num,
  output logic [CAP_NUM-1:0] sw,
  output logic               sw_upd,
  output logic               cal_done,
  output logic               err_cfg
);

  localparam logic [1:0]         M_STATIC = 2'b00;
  localparam logic [1:0]         M_ROT    = 2'b01;
  localparam logic [1:0]         M_CAL    = 2'b10;
  localparam logic [CNT_W-1:0]   CAP_CNT  = CNT_W'(CAP_NUM);
  localparam logic [CNT_W:0]     CAP_SUM  = (CNT_W+1)'(CAP_NUM);
  localparam logic [CAP_NUM-1:0] ONEHOT0  = CAP_NUM'(1);

  typedef enum logic [1:0] {IDLE, RUN, CAL} state_t;

  state_t             state, state_n;
  logic [FRAME_W-1:0] frame_cnt;
  logic               pend;
  logic [1:0]         p_mode, a_mode;
  logic [CNT_W-1:0]   p_num, a_num;
  logic [PTR_W-1:0]   ptr, ptr_n, eff_ptr;
  logic [CAP_NUM-1:0] sw_n, low_mask, rot_mask;
  logic [CNT_W:0]     ptr_sum;
  logic [1:0]         eff_mode;
  logic [CNT_W-1:0]   eff_num;
  logic               tick, xfer, use_pend, cal_fin, over;

  assign tick      = (frame_cnt == frame_len);
  assign cfg_ready = !pend && (state != CAL);
  assign xfer      = cfg_valid && cfg_ready;
  assign over      = (cfg_num > CAP_CNT);

  // Select the config that governs this tick and build the candidate masks
  always_comb begin
    use_pend = pend && (state != CAL);
    eff_mode = use_pend ? p_mode : a_mode;
    eff_num  = use_pend ? p_num  : a_num;
    // A mode change restarts the rotation from bit 0
    eff_ptr  = (use_pend && (p_mode != a_mode)) ? '0 : ptr;
    low_mask = ~({CAP_NUM{1'b1}} << eff_num);
    // Rotate left by eff_ptr; a shift by CAP_NUM yields 0, covering ptr=0
    rot_mask = (low_mask << eff_ptr) | (low_mask >> (CAP_NUM - int'(eff_ptr)));
    ptr_sum  = (CNT_W+1)'(eff_ptr) + (CNT_W+1)'(eff_num);
  end

  // Next-state, next-sw and next-pointer, consumed only on a tick
  always_comb begin
    state_n = state;
    sw_n    = sw;
    ptr_n   = ptr;
    cal_fin = 1'b0;
    if (state == CAL) begin
      if (sw[CAP_NUM-1]) begin
        sw_n    = '0;
        state_n = IDLE;
        cal_fin = 1'b1;
      end else begin
        sw_n = sw << 1;
      end
    end else if (state == RUN || pend) begin
      ptr_n = eff_ptr;
      case (eff_mode)
        M_STATIC: begin
          state_n = RUN;
          sw_n    = low_mask;
        end
        M_ROT: begin
          state_n = RUN;
          sw_n    = rot_mask;
          ptr_n   = (ptr_sum >= CAP_SUM) ? PTR_W'(ptr_sum - CAP_SUM) : PTR_W'(ptr_sum);
        end
        M_CAL: begin
          state_n = CAL;
          sw_n    = ONEHOT0;
        end
        default: begin
          state_n = IDLE;
          sw_n    = '0;
        end
      endcase
    end
  end

  // Frame counter, config staging and frame-boundary state update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      pend      <= 1'b0;
      p_mode    <= 2'b11;
      p_num     <= '0;
      a_mode    <= 2'b11;
      a_num     <= '0;
      ptr       <= '0;
      sw        <= '0;
      sw_upd    <= 1'b0;
      cal_done  <= 1'b0;
      err_cfg   <= 1'b0;
    end else begin
      frame_cnt <= tick ? '0 : frame_cnt + FRAME_W'(1);
      sw_upd    <= 1'b0;
      cal_done  <= 1'b0;
      err_cfg   <= 1'b0;
      // A transfer needs pend=0, so it never collides with a pending apply
      if (xfer) begin
        pend    <= 1'b1;
        p_mode  <= cfg_mode;
        p_num   <= over ? CAP_CNT : cfg_num;
        err_cfg <= over;
      end
      if (tick) begin
        state    <= state_n;
        sw       <= sw_n;
        ptr      <= ptr_n;
        sw_upd   <= (sw_n != sw);
        cal_done <= cal_fin;
        if (use_pend) begin
          pend   <= 1'b0;
          a_mode <= p_mode;
          a_num  <= p_num;
        end
      end
    end
  end

endmodule

// File: tb/tb_route_sw_scheduler.sv
// Directed bench for route_sw_scheduler: reset, rotate, static/clamp,
// calibration walk, tick-coincident config, frame shrink, reset mid-walk.
module tb_route_sw_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] frame_len;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_num;
  logic [7:0] sw;
  logic       sw_upd, cal_done, err_cfg;

  int errors = 0;
  int checks = 0;

  route_sw_scheduler #(.CAP_NUM(8), .CNT_W(4), .PTR_W(3), .FRAME_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_len(frame_len),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_num(cfg_num), .sw(sw), .sw_upd(sw_upd), .cal_done(cal_done),
    .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_upd(input int bound, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < bound && !seen) begin
      cyc();
      n++;
      if (sw_upd) seen = 1'b1;
    end
  endtask

  task automatic send_cfg(input logic [1:0] m, input logic [3:0] num, output bit ok);
    cfg_mode  = m;
    cfg_num   = num;
    cfg_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (cfg_ready) ok = 1'b1;
      cyc();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    int upd_cnt, nz_cnt;
    rst_n = 1'b0; frame_len = 8'd3; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_num = 4'd0;
    cyc(); cyc();
    checks++; if (sw !== 8'h00) begin errors++; $display("FAIL reset_sw: got %h exp 00", sw); end
    checks++; if ({sw_upd, cal_done, err_cfg} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b exp 000", {sw_upd, cal_done, err_cfg}); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", cfg_ready); end
    rst_n = 1'b1;
    upd_cnt = 0; nz_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (sw_upd !== 1'b0) upd_cnt++;
      if (sw !== 8'h00) nz_cnt++;
    end
    checks++; if (upd_cnt != 0) begin errors++; $display("FAIL idle_upd: got %0d pulses exp 0", upd_cnt); end
    checks++; if (nz_cnt != 0) begin errors++; $display("FAIL idle_sw: got %0d nonzero cycles exp 0", nz_cnt); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b exp 1", cfg_ready); end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_rot [4] = '{8'h07, 8'h38, 8'hC1, 8'h0E};
    bit ok, seen;
    int n;
    send_cfg(2'b01, 4'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rot_accept: got 0 exp 1"); end
    for (int k = 0; k < 4; k++) begin
      wait_upd(12, n, seen);
      checks++; if (!seen) begin errors++; $display("FAIL rot_upd%0d: got timeout exp pulse", k); end
      checks++; if (sw !== exp_rot[k]) begin errors++; $display("FAIL rot_sw%0d: got %h exp %h", k, sw, exp_rot[k]); end
      if (k > 0) begin
        checks++; if (n != 4) begin errors++; $display("FAIL rot_period%0d: got %0d exp 4", k, n); end
      end
    end
  endtask

  task automatic test_static_clamp();
    bit ok, seen;
    int n, upd_cnt;
    send_cfg(2'b00, 4'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL st_accept: got 0 exp 1"); end
    wait_upd(12, n, seen);
    checks++; if (!seen || n != 3) begin errors++; $display("FAIL st_latency: got %0d exp 3", n); end
    checks++; if (sw !== 8'h1F) begin errors++; $display("FAIL st_sw5: got %h exp 1f", sw); end
    send_cfg(2'b00, 4'd12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clamp_accept: got 0 exp 1"); end
    checks++; if (err_cfg !== 1'b1) begin errors++; $display("FAIL clamp_err: got %b exp 1", err_cfg); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL clamp_ready0: got %b exp 0", cfg_ready); end
    cyc();
    checks++; if (err_cfg !== 1'b0) begin errors++; $display("FAIL clamp_err_once: got %b exp 0", err_cfg); end
    checks++; if (sw !== 8'h1F) begin errors++; $display("FAIL clamp_hold1: got %h exp 1f", sw); end
    cyc();
    checks++; if ({cfg_ready, sw_upd} !== 2'b00) begin errors++; $display("FAIL clamp_ready1: got %b exp 00", {cfg_ready, sw_upd}); end
    cyc();
    checks++; if (sw !== 8'hFF) begin errors++; $display("FAIL clamp_sw: got %h exp ff", sw); end
    checks++; if ({sw_upd, cfg_ready} !== 2'b11) begin errors++; $display("FAIL clamp_upd_ready: got %b exp 11", {sw_upd, cfg_ready}); end
    upd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (sw_upd !== 1'b0) upd_cnt++;
    end
    checks++; if (upd_cnt != 0 || sw !== 8'hFF) begin errors++; $display("FAIL static_repeat: got %0d pulses sw %h exp 0 ff", upd_cnt, sw); end
  endtask

  task automatic test_cal();
    bit ok;
    logic [7:0] exp_oh;
    int bad;
    frame_len = 8'd0;
    send_cfg(2'b10, 4'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cal_accept: got 0 exp 1"); end
    checks++; if ({cfg_ready, sw_upd, sw} !== {2'b00, 8'hFF}) begin errors++; $display("FAIL cal_pending: got %b %b %h exp 0 0 ff", cfg_ready, sw_upd, sw); end
    cfg_mode = 2'b00; cfg_num = 4'd2; cfg_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      exp_oh = 8'h01 << i;
      checks++; if (sw !== exp_oh) begin errors++; $display("FAIL cal_walk%0d: got %h exp %h", i, sw, exp_oh); end
      checks++; if ({sw_upd, cfg_ready, cal_done} !== 3'b100) begin errors++; $display("FAIL cal_flags%0d: got %b exp 100", i, {sw_upd, cfg_ready, cal_done}); end
    end
    cfg_valid = 1'b0;
    cyc();
    checks++; if (sw !== 8'h00) begin errors++; $display("FAIL cal_end_sw: got %h exp 00", sw); end
    checks++; if ({cal_done, cfg_ready} !== 2'b11) begin errors++; $display("FAIL cal_done: got %b exp 11", {cal_done, cfg_ready}); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (sw !== 8'h00 || cal_done !== 1'b0 || sw_upd !== 1'b0 || err_cfg !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL cal_ignored_cfg: got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_back_to_back();
    bit ok, seen;
    int n;
    frame_len = 8'd3;
    send_cfg(2'b01, 4'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept: got 0 exp 1"); end
    cyc(); cyc(); cyc();
    checks++; if ({sw_upd, sw} !== {1'b1, 8'h07}) begin errors++; $display("FAIL b2b_first: got %b %h exp 1 07", sw_upd, sw); end
    cyc(); cyc(); cyc();
    cfg_mode = 2'b01; cfg_num = 4'd2; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    checks++; if (sw !== 8'h38) begin errors++; $display("FAIL b2b_coincide_old: got %h exp 38", sw); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_coincide_pend: got %b exp 0", cfg_ready); end
    cyc(); cyc(); cyc();
    checks++; if (sw !== 8'h38) begin errors++; $display("FAIL b2b_hold: got %h exp 38", sw); end
    cyc();
    checks++; if ({sw_upd, sw} !== {1'b1, 8'hC0}) begin errors++; $display("FAIL b2b_keep_ptr: got %b %h exp 1 c0", sw_upd, sw); end
    send_cfg(2'b00, 4'd4, ok);
    wait_upd(12, n, seen);
    checks++; if (!seen || sw !== 8'h0F) begin errors++; $display("FAIL b2b_static: got %h exp 0f", sw); end
    send_cfg(2'b01, 4'd2, ok);
    wait_upd(12, n, seen);
    checks++; if (!seen || sw !== 8'h03) begin errors++; $display("FAIL b2b_ptr_reset: got %h exp 03", sw); end
    wait_upd(12, n, seen);
    checks++; if (!seen || sw !== 8'h0C) begin errors++; $display("FAIL b2b_ptr_adv: got %h exp 0c", sw); end
  endtask

  task automatic test_frame_shrink();
    bit seen;
    int n, upd_cnt;
    frame_len = 8'd10;
    upd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (sw_upd !== 1'b0) upd_cnt++;
    end
    checks++; if (upd_cnt != 0) begin errors++; $display("FAIL shrink_pre: got %0d pulses exp 0", upd_cnt); end
    frame_len = 8'd2;
    wait_upd(300, n, seen);
    checks++; if (!seen || n != 254) begin errors++; $display("FAIL shrink_wrap: got %0d cycles exp 254", n); end
    checks++; if (sw !== 8'h30) begin errors++; $display("FAIL shrink_sw: got %h exp 30", sw); end
  endtask

  task automatic test_reset_cal();
    bit ok;
    int bad;
    frame_len = 8'd0;
    send_cfg(2'b10, 4'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rcal_accept: got 0 exp 1"); end
    for (int i = 0; i < 5; i++) cyc();
    checks++; if (sw !== 8'h10) begin errors++; $display("FAIL rcal_bit4: got %h exp 10", sw); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++; if (sw !== 8'h00) begin errors++; $display("FAIL rcal_sw: got %h exp 00", sw); end
    checks++; if ({cfg_ready, cal_done, sw_upd} !== 3'b100) begin errors++; $display("FAIL rcal_flags: got %b exp 100", {cfg_ready, cal_done, sw_upd}); end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (cal_done !== 1'b0 || sw !== 8'h00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rcal_no_done: got %0d bad cycles exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_static_clamp();
    test_cal();
    test_back_to_back();
    test_frame_shrink();
    test_reset_cal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
